axi_read_arbiter: RTL

// - Shares one AXI read slave (AR + R channels) between NUM_MASTERS requesters (e.g. I-fetch, D-cache).
// - Grants one requester per burst and routes its AR to the slave and the slave's R beats back to it.
// - Grant is held from AR handshake until the RLAST beat handshake; no interleaving.
// - Sits between the core-side read masters and the memory-side read slave.

---
 rtl/axi_read_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// ============================================================================
// Module   : axi_read_arbiter
// Purpose  : Shares one AXI read slave between NUM_MASTERS requesters. One burst
//            is granted at a time, and the grant is held until the RLAST beat.
// Options  : define ARB_RR_EN for round-robin arbitration. Without it, the
//            arbiter uses fixed priority, where the lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_read_arbiter #(
  parameter int NUM_MASTERS        = 2,
  parameter int ADDR_WIDTH         = 32,
  parameter int READ_CHANNEL_WIDTH = 32,
  parameter int READ_BURST_LEN     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_MASTERS-1:0]                 s_ARVALID,
  output logic [NUM_MASTERS-1:0]                 s_ARREADY,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      s_ARADDR,
  input  logic [NUM_MASTERS*READ_BURST_LEN-1:0]  s_ARLEN,
  input  logic [NUM_MASTERS*3-1:0]               s_ARSIZE,
  input  logic [NUM_MASTERS*2-1:0]               s_ARBURST,
  output logic [NUM_MASTERS-1:0]                 s_RVALID,
  input  logic [NUM_MASTERS-1:0]                 s_RREADY,
  output logic [READ_CHANNEL_WIDTH-1:0]          s_RDATA,
  output logic                                   s_RLAST,
  output logic [1:0]                             s_RRESP,
  output logic                                   m_ARVALID,
  input  logic                                   m_ARREADY,
  output logic [ADDR_WIDTH-1:0]                  m_ARADDR,
  output logic [READ_BURST_LEN-1:0]              m_ARLEN,
  output logic [2:0]                             m_ARSIZE,
  output logic [1:0]                             m_ARBURST,
  input  logic                                   m_RVALID,
  output logic                                   m_RREADY,
  input  logic [READ_CHANNEL_WIDTH-1:0]          m_RDATA,
  input  logic                                   m_RLAST,
  input  logic [1:0]                             m_RRESP,
  output logic [NUM_MASTERS-1:0]                 grant,
  output logic                                   err_len
);

  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNTW = READ_BURST_LEN + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                    state_q;
  logic [NUM_MASTERS-1:0]    grant_q;
  logic [NUM_MASTERS-1:0]    grant_d;
  logic [IDXW-1:0]           gidx_q;
  logic [READ_BURST_LEN-1:0] len_q;
  logic [CNTW-1:0]           cnt_q;
  logic                      err_q;
  logic [IDXW-1:0]           win_idx;
  logic                      win_found;

`ifdef ARB_RR_EN
  logic [IDXW-1:0]           ptr_q;
  int                        rr_cand;

  // Scan the requesters starting at the pointer. The first active one wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    rr_cand   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rr_cand = (int'(ptr_q) + i) % NUM_MASTERS;
      if (!win_found && s_ARVALID[rr_cand]) begin
        win_found = 1'b1;
        win_idx   = IDXW'(rr_cand);
      end
    end
  end
`else
  always_comb begin
    win_idx   = '0;
    win_found = |s_ARVALID;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (s_ARVALID[i]) win_idx = IDXW'(i);
    end
  end
`endif

  always_comb begin
    grant_d = '0;
    if (win_found) grant_d[win_idx] = 1'b1;
  end

  always_comb begin
    s_ARREADY = '0;
    s_RVALID  = '0;
    s_RDATA   = '0;
    s_RLAST   = 1'b0;
    s_RRESP   = '0;
    m_ARVALID = 1'b0;
    m_ARADDR  = '0;
    m_ARLEN   = '0;
    m_ARSIZE  = '0;
    m_ARBURST = '0;
    m_RREADY  = 1'b0;
    if (state_q == ST_ADDR) begin
      m_ARVALID         = s_ARVALID[gidx_q];
      s_ARREADY[gidx_q] = m_ARREADY;
      m_ARADDR          = s_ARADDR[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
      m_ARLEN           = s_ARLEN[gidx_q*READ_BURST_LEN +: READ_BURST_LEN];
      m_ARSIZE          = s_ARSIZE[gidx_q*3 +: 3];
      m_ARBURST         = s_ARBURST[gidx_q*2 +: 2];
    end else if (state_q == ST_DATA) begin
      s_RVALID[gidx_q]  = m_RVALID;
      m_RREADY          = s_RREADY[gidx_q];
      s_RDATA           = m_RDATA;
      s_RLAST           = m_RLAST;
      s_RRESP           = m_RRESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_q <= grant_d;
            gidx_q  <= win_idx;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_ARVALID && m_ARREADY) begin
            len_q   <= m_ARLEN;
            cnt_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_RVALID && m_RREADY) begin
            // Saturate the counter so that a runaway slave cannot wrap it back to a matching count.
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (m_RLAST) begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              if (cnt_q != {1'b0, len_q}) err_q <= 1'b1;
`ifdef ARB_RR_EN
              ptr_q   <= (gidx_q == IDXW'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
`endif
            end else if (cnt_q >= {1'b0, len_q}) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign err_len = err_q;

endmodule

`default_nettype wire
